// File: rtl/c_gate_pkg.sv
// Types and limits shared by the hold-gated bit gating blocks.
package c_gate_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    HOLD   = 2'b10
  } hold_state_t;

  localparam int C_MAX_STAGES = 4;
  localparam int C_MAX_HOLD   = 255;

  // Hold counter must still exist as one bit when hold_cycles is 0.
  function automatic int cnt_width(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/c_binary_op.sv
// Bitwise reduction of num_ports equal-width words with a selectable binary op.
`ifndef C_CONSTANTS_SV
`include "c_constants.sv"
`endif

module c_binary_op #(
  parameter int num_ports = 2,
  parameter int width     = 32,
  parameter int op        = `BINARY_OP_AND
) (
  input  logic [0:num_ports*width-1] data_in,
  output logic [0:width-1]           data_out
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < width; gi++) begin : g_bit
      logic [0:num_ports-1] w_bits;
      for (gj = 0; gj < num_ports; gj++) begin : g_gather
        assign w_bits[gj] = data_in[gj*width + gi];
      end

      case (op)
        `BINARY_OP_NAND: begin : g_nand
          assign data_out[gi] = ~&w_bits;
        end
        `BINARY_OP_OR: begin : g_or
          assign data_out[gi] = |w_bits;
        end
        `BINARY_OP_NOR: begin : g_nor
          assign data_out[gi] = ~|w_bits;
        end
        `BINARY_OP_XOR: begin : g_xor
          assign data_out[gi] = ^w_bits;
        end
        `BINARY_OP_XNOR: begin : g_xnor
          assign data_out[gi] = ~^w_bits;
        end
        default: begin : g_and
          assign data_out[gi] = &w_bits;
        end
      endcase
    end
  endgenerate

endmodule

// File: rtl/c_constants.sv
// Shared op-code constants for the c_* block library.
`ifndef C_CONSTANTS_SV
`define C_CONSTANTS_SV

`define BINARY_OP_AND  0
`define BINARY_OP_NAND 1
`define BINARY_OP_OR   2
`define BINARY_OP_NOR  3
`define BINARY_OP_XOR  4
`define BINARY_OP_XNOR 5

`endif

// File: rtl/c_gate_hold_ctrl.sv
// One port's select FSM and hold-off counter; drives the stage-0 load enable.
// Optional expiry statistics counter under C_GATE_BITS_HOLD_STATS_EN.
module c_gate_hold_ctrl
  import c_gate_pkg::*;
#(
  parameter int hold_cycles = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_select,
  output logic       o_load,
  output logic       o_gate,
  output logic       o_holding
`ifdef C_GATE_BITS_HOLD_STATS_EN
  ,
  output logic [7:0] o_expired_cnt
`endif
);

  localparam int CNT_W = cnt_width(hold_cycles);
  localparam logic [CNT_W-1:0] CNT_INIT =
      (hold_cycles > 0) ? CNT_W'(hold_cycles - 1) : '0;

  hold_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load;
  logic             w_expire;

  assign w_expire = (r_state == HOLD) && !i_select && (r_cnt == '0);

  // Stage 0 freezes only while the last active value must persist.
  always_comb begin
    w_load = 1'b1;
    if (!i_select) begin
      if ((r_state == ACTIVE) && (hold_cycles > 0)) w_load = 1'b0;
      if ((r_state == HOLD) && (r_cnt != '0))       w_load = 1'b0;
    end
  end

  assign o_load    = w_load;
  assign o_gate    = i_select;
  assign o_holding = (r_state == HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_select) r_state <= ACTIVE;
        end
        ACTIVE: begin
          if (!i_select) begin
            if (hold_cycles > 0) begin
              r_state <= HOLD;
              r_cnt   <= CNT_INIT;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        HOLD: begin
          if (i_select)          r_state <= ACTIVE;
          else if (r_cnt != '0)  r_cnt   <= r_cnt - CNT_W'(1);
          else                   r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef C_GATE_BITS_HOLD_STATS_EN
  logic [7:0] r_expired_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_expired_cnt <= 8'd0;
    else if (w_expire && (r_expired_cnt != 8'hFF))
      r_expired_cnt <= r_expired_cnt + 8'd1;
  end

  assign o_expired_cnt = r_expired_cnt;
`else
  logic w_unused_expire;
  assign w_unused_expire = w_expire;
`endif

endmodule

// File: rtl/c_gate_bits_hold.sv
// Multi-port registered gate-(op) with per-port select hold-off and output pipeline.
// Optional per-port expiry counters under C_GATE_BITS_HOLD_STATS_EN.
`ifndef C_CONSTANTS_SV
`include "c_constants.sv"
`endif

module c_gate_bits_hold
  import c_gate_pkg::*;
#(
  parameter int num_ports   = 1,
  parameter int width       = 32,
  parameter int op          = `BINARY_OP_AND,
  parameter int hold_cycles = 2,
  parameter int num_stages  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [0:num_ports-1]       select,
  input  logic [0:num_ports*width-1] data_in,
  output logic [0:num_ports*width-1] data_out,
  output logic [0:num_ports-1]       holding
`ifdef C_GATE_BITS_HOLD_STATS_EN
  ,
  output logic [0:num_ports*8-1]     hold_expired_cnt
`endif
);

  logic [0:num_ports*width-1] w_s0;

  genvar gi;
  generate
    if ((num_stages < 1) || (num_stages > C_MAX_STAGES)) begin : g_bad_stages
      $error("c_gate_bits_hold: num_stages must be within 1..4");
    end
    if ((hold_cycles < 0) || (hold_cycles > C_MAX_HOLD)) begin : g_bad_hold
      $error("c_gate_bits_hold: hold_cycles must be within 0..255");
    end

    for (gi = 0; gi < num_ports; gi++) begin : g_port
      logic             w_load;
      logic             w_gate;
      logic [0:width-1] w_gated;
      logic [0:width-1] r_s0;

      c_gate_hold_ctrl #(
        .hold_cycles(hold_cycles)
      ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .i_select     (select[gi]),
        .o_load       (w_load),
        .o_gate       (w_gate),
        .o_holding    (holding[gi])
`ifdef C_GATE_BITS_HOLD_STATS_EN
        ,
        .o_expired_cnt(hold_expired_cnt[gi*8 +: 8])
`endif
      );

      // Word 0 is the replicated gate bit, word 1 the port data.
      c_binary_op #(
        .num_ports(2),
        .width    (width),
        .op       (op)
      ) u_op (
        .data_in ({{width{w_gate}}, data_in[gi*width +: width]}),
        .data_out(w_gated)
      );

      always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_s0 <= '0;
        else if (w_load) r_s0 <= w_gated;
      end

      assign w_s0[gi*width +: width] = r_s0;
    end

    if (num_stages == 1) begin : g_no_pipe
      assign data_out = w_s0;
    end else begin : g_pipe
      logic [0:num_ports*width-1] r_pipe [1:num_stages-1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 1; i < num_stages; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[1] <= w_s0;
          for (int i = 2; i < num_stages; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign data_out = r_pipe[num_stages-1];
    end
  endgenerate

endmodule

// File: tb/tb_c_gate_bits_hold.sv
// Scoreboard bench for c_gate_bits_hold: a 2-port AND/hold=3/2-stage instance and
// a 1-port OR/hold=0/1-stage instance.
`ifndef C_CONSTANTS_SV
`include "c_constants.sv"
`endif

module tb_c_gate_bits_hold;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, reset_b;
  logic [0:1]  sel_a;
  logic [0:15] din_a, dout_a;
  logic [0:1]  hold_a;
  logic [0:0]  sel_b;
  logic [0:7]  din_b, dout_b;
  logic [0:0]  hold_b;
`ifdef C_GATE_BITS_HOLD_STATS_EN
  logic [0:15] cnt_a;
  logic [0:7]  cnt_b;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] out;
    logic [1:0]  hold;
  } exp_t;

  typedef struct packed {
    logic [1:0]  s;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [15:0] eo;
    logic [1:0]  eh;
  } row_t;

  exp_t sb_q[$];

  c_gate_bits_hold #(
    .num_ports(2), .width(8), .op(`BINARY_OP_AND), .hold_cycles(3), .num_stages(2)
  ) u_dut_a (
    .clk             (clk),
    .reset           (reset_a),
    .select          (sel_a),
    .data_in         (din_a),
    .data_out        (dout_a),
    .holding         (hold_a)
`ifdef C_GATE_BITS_HOLD_STATS_EN
    ,
    .hold_expired_cnt(cnt_a)
`endif
  );

  c_gate_bits_hold #(
    .num_ports(1), .width(8), .op(`BINARY_OP_OR), .hold_cycles(0), .num_stages(1)
  ) u_dut_b (
    .clk             (clk),
    .reset           (reset_b),
    .select          (sel_b),
    .data_in         (din_b),
    .data_out        (dout_b),
    .holding         (hold_b)
`ifdef C_GATE_BITS_HOLD_STATS_EN
    ,
    .hold_expired_cnt(cnt_b)
`endif
  );

  // Applies one row at the negedge, records its expectation, then advances to the next negedge.
  task automatic drive_a(input row_t r);
    sel_a = r.s;
    din_a = {r.d0, r.d1};
    sb_q.push_back('{out: r.eo, hold: r.eh});
    @(posedge clk);
    @(negedge clk);
    $display("tx A sel=%b din=%h -> dout=%h holding=%b", r.s, {r.d0, r.d1}, dout_a, hold_a);
  endtask

  task automatic drive_b(input logic s, input logic [7:0] d, input logic [7:0] eo);
    sel_b = s;
    din_b = d;
    sb_q.push_back('{out: {8'h00, eo}, hold: 2'b00});
    @(posedge clk);
    @(negedge clk);
    $display("tx B sel=%b din=%h -> dout=%h holding=%b", s, d, dout_b, hold_b);
  endtask

  task automatic test_reset();
    exp_t e;
    row_t rows [2];
    row_t idle_rows [3];
    reset_a = 1'b1; reset_b = 1'b1;
    sel_a = 2'b00; din_a = 16'h1234; sel_b = 1'b0; din_b = 8'h00;
    @(negedge clk);
    total++;
    if (dout_a !== 16'h0000) begin bad++; $display("FAIL reset_dout got %h want 0000", dout_a); end
    total++;
    if (hold_a !== 2'b00) begin bad++; $display("FAIL reset_holding got %b want 00", hold_a); end
    reset_a = 1'b0; reset_b = 1'b0;
    rows = '{'{2'b10, 8'hA5, 8'h5A, 16'h0000, 2'b00},
             '{2'b00, 8'h3C, 8'h5A, 16'hA500, 2'b10}};
    foreach (rows[i]) begin
      drive_a(rows[i]);
      e = sb_q.pop_front();
      total++;
      if (dout_a !== e.out) begin bad++; $display("FAIL reset_pre[%0d] dout got %h want %h", i, dout_a, e.out); end
      total++;
      if (hold_a !== e.hold) begin bad++; $display("FAIL reset_pre[%0d] holding got %b want %b", i, hold_a, e.hold); end
    end
    #2 reset_a = 1'b1;
    #1;
    total++;
    if (dout_a !== 16'h0000) begin bad++; $display("FAIL reset_mid_hold dout got %h want 0000", dout_a); end
    total++;
    if (hold_a !== 2'b00) begin bad++; $display("FAIL reset_mid_hold holding got %b want 00", hold_a); end
    @(negedge clk);
    reset_a = 1'b0;
    idle_rows = '{'{2'b00, 8'hFF, 8'hFF, 16'h0000, 2'b00},
                  '{2'b00, 8'hFF, 8'hFF, 16'h0000, 2'b00},
                  '{2'b00, 8'hFF, 8'hFF, 16'h0000, 2'b00}};
    foreach (idle_rows[i]) begin
      drive_a(idle_rows[i]);
      e = sb_q.pop_front();
      total++;
      if (dout_a !== e.out) begin bad++; $display("FAIL reset_release[%0d] dout got %h want %h", i, dout_a, e.out); end
      total++;
      if (hold_a !== e.hold) begin bad++; $display("FAIL reset_release[%0d] holding got %b want %b", i, hold_a, e.hold); end
    end
  endtask

  task automatic test_active_pass();
    exp_t e;
    row_t rows [2];
    rows = '{'{2'b10, 8'hA5, 8'hFF, 16'h0000, 2'b00},
             '{2'b10, 8'hA5, 8'h77, 16'hA500, 2'b00}};
    foreach (rows[i]) begin
      drive_a(rows[i]);
      e = sb_q.pop_front();
      total++;
      if (dout_a !== e.out) begin bad++; $display("FAIL active[%0d] dout got %h want %h", i, dout_a, e.out); end
      total++;
      if (hold_a !== e.hold) begin bad++; $display("FAIL active[%0d] holding got %b want %b", i, hold_a, e.hold); end
    end
  endtask

  task automatic test_hold_expiry();
    exp_t e;
    row_t rows [5];
    rows = '{'{2'b00, 8'h3C, 8'h77, 16'hA500, 2'b10},
             '{2'b00, 8'h3C, 8'h77, 16'hA500, 2'b10},
             '{2'b00, 8'h3C, 8'h77, 16'hA500, 2'b10},
             '{2'b00, 8'h3C, 8'h77, 16'hA500, 2'b00},
             '{2'b00, 8'h3C, 8'h77, 16'h0000, 2'b00}};
    foreach (rows[i]) begin
      drive_a(rows[i]);
      e = sb_q.pop_front();
      total++;
      if (dout_a !== e.out) begin bad++; $display("FAIL hold[%0d] dout got %h want %h", i, dout_a, e.out); end
      total++;
      if (hold_a !== e.hold) begin bad++; $display("FAIL hold[%0d] holding got %b want %b", i, hold_a, e.hold); end
    end
  endtask

  task automatic test_reselect();
    exp_t e;
    row_t rows [4];
    rows = '{'{2'b10, 8'h11, 8'h00, 16'h0000, 2'b00},
             '{2'b00, 8'h22, 8'h00, 16'h1100, 2'b10},
             '{2'b10, 8'h5A, 8'h00, 16'h1100, 2'b00},
             '{2'b10, 8'h5A, 8'h00, 16'h5A00, 2'b00}};
    foreach (rows[i]) begin
      drive_a(rows[i]);
      e = sb_q.pop_front();
      total++;
      if (dout_a !== e.out) begin bad++; $display("FAIL reselect[%0d] dout got %h want %h", i, dout_a, e.out); end
      total++;
      if (hold_a !== e.hold) begin bad++; $display("FAIL reselect[%0d] holding got %b want %b", i, hold_a, e.hold); end
    end
`ifdef C_GATE_BITS_HOLD_STATS_EN
    total++;
    if (cnt_a !== 16'h0100) begin bad++; $display("FAIL reselect_stats got %h want 0100", cnt_a); end
`endif
  endtask

  task automatic test_independent();
    exp_t e;
    row_t rows [7];
    rows = '{'{2'b01, 8'h99, 8'hC3, 16'h5A00, 2'b10},
             '{2'b01, 8'h99, 8'hC3, 16'h5AC3, 2'b10},
             '{2'b00, 8'h99, 8'hE1, 16'h5AC3, 2'b11},
             '{2'b00, 8'h99, 8'hE1, 16'h5AC3, 2'b01},
             '{2'b00, 8'h99, 8'hE1, 16'h00C3, 2'b01},
             '{2'b00, 8'h99, 8'hE1, 16'h00C3, 2'b00},
             '{2'b00, 8'h99, 8'hE1, 16'h0000, 2'b00}};
    foreach (rows[i]) begin
      drive_a(rows[i]);
      e = sb_q.pop_front();
      total++;
      if (dout_a !== e.out) begin bad++; $display("FAIL indep[%0d] dout got %h want %h", i, dout_a, e.out); end
      total++;
      if (hold_a !== e.hold) begin bad++; $display("FAIL indep[%0d] holding got %b want %b", i, hold_a, e.hold); end
    end
`ifdef C_GATE_BITS_HOLD_STATS_EN
    total++;
    if (cnt_a !== 16'h0201) begin bad++; $display("FAIL indep_stats got %h want 0201", cnt_a); end
`endif
  endtask

  task automatic test_hold_zero();
    exp_t e;
    logic       s_tab [7];
    logic [7:0] d_tab [7];
    logic [7:0] x_tab [7];
    s_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    d_tab = '{8'h0F, 8'h0F, 8'h3C, 8'h00, 8'h00, 8'hC3, 8'hC3};
    x_tab = '{8'hFF, 8'h0F, 8'h3C, 8'hFF, 8'h00, 8'hFF, 8'hC3};
    foreach (s_tab[i]) begin
      drive_b(s_tab[i], d_tab[i], x_tab[i]);
      e = sb_q.pop_front();
      total++;
      if (dout_b !== e.out[7:0]) begin bad++; $display("FAIL hold0[%0d] dout got %h want %h", i, dout_b, e.out[7:0]); end
      total++;
      if (hold_b !== 1'b0) begin bad++; $display("FAIL hold0[%0d] holding got %b want 0", i, hold_b); end
    end
  endtask

`ifdef C_GATE_BITS_HOLD_STATS_EN
  task automatic test_stats();
    exp_t e;
    row_t rows [5];
    int   out_bad;
    reset_a = 1'b1;
    sel_a = 2'b00;
    @(negedge clk);
    total++;
    if (cnt_a !== 16'h0000) begin bad++; $display("FAIL stats_reset got %h want 0000", cnt_a); end
    reset_a = 1'b0;
    rows = '{'{2'b10, 8'hA5, 8'h77, 16'h0000, 2'b00},
             '{2'b00, 8'hA5, 8'h77, 16'hA500, 2'b10},
             '{2'b00, 8'hA5, 8'h77, 16'hA500, 2'b10},
             '{2'b00, 8'hA5, 8'h77, 16'hA500, 2'b10},
             '{2'b00, 8'hA5, 8'h77, 16'hA500, 2'b00}};
    out_bad = 0;
    for (int p = 1; p <= 300; p++) begin
      foreach (rows[i]) begin
        drive_a(rows[i]);
        e = sb_q.pop_front();
        if ((dout_a !== e.out) || (hold_a !== e.hold)) out_bad++;
      end
      if ((p == 1) || (p == 254)) begin
        total++;
        if (cnt_a[0:7] !== p[7:0]) begin bad++; $display("FAIL stats_pulse%0d got %0d want %0d", p, cnt_a[0:7], p); end
      end
    end
    total++;
    if (out_bad != 0) begin bad++; $display("FAIL stats_outputs got %0d bad cycles want 0", out_bad); end
    total++;
    if (cnt_a[0:7] !== 8'd255) begin bad++; $display("FAIL stats_saturate got %0d want 255", cnt_a[0:7]); end
    total++;
    if (cnt_a[8:15] !== 8'd0) begin bad++; $display("FAIL stats_other_port got %0d want 0", cnt_a[8:15]); end
    total++;
    if (cnt_b !== 8'd0) begin bad++; $display("FAIL stats_hold0 got %0d want 0", cnt_b); end
  endtask
`endif

  initial begin
    test_reset();
    test_active_pass();
    test_hold_expiry();
    test_reselect();
    test_independent();
    test_hold_zero();
`ifdef C_GATE_BITS_HOLD_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c_gate_bits_hold.md
Name: c_gate_bits_hold

Overview:
- Registered, multi-port successor of the combinational per-port gate-(op) block.
- Each port's data word is combined bitwise with its replicated select bit using a configurable binary op.
- Adds a per-port hold-off timer: after a select deassertion, the last active value persists for hold_cycles cycles before the gated value takes effect.
- Adds a configurable output pipeline. Used in router control paths to suppress select glitches and to retime gated vectors.

Parameters:
- num_ports, 1, number of independent ports.
- width, 32, bits per port.
- op, `BINARY_OP_AND, binary op from c_constants.sv; applied as op(replicated select/gate bit, data).
- hold_cycles, 2, cycles the last active value is held after select falls; 0 to 255; 0 gates immediately.
- num_stages, 1, register stages from input to data_out; 1 to 4.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- select  input  [0:num_ports-1]  per-port active select.
- data_in  input  [0:num_ports*width-1]  port p occupies [p*width:(p+1)*width-1].
- data_out  output  [0:num_ports*width-1]  gated, registered result, same packing as data_in.
- holding  output  [0:num_ports-1]  per-port flag; 1 while that port is in HOLD.

Behaviour:
- Per-port FSM states: IDLE, ACTIVE, HOLD. Each port has a hold counter of width clog2(hold_cycles+1), minimum 1 bit.
- Reset, asynchronous: all ports go to IDLE, counter 0, all stage registers 0. data_out = 0 and holding = 0 while reset is high and after release until the first capture.
- Stage-0 register s0[p] is updated per state at each rising edge:
  - IDLE, select=1: s0 <= op(all-1, data); next state ACTIVE.
  - IDLE, select=0: s0 <= op(all-0, data); stay in IDLE.
  - ACTIVE, select=1: s0 <= op(all-1, data).
  - ACTIVE, select=0, hold_cycles>0: s0 held; next state HOLD; cnt <= hold_cycles-1.
  - ACTIVE, select=0, hold_cycles=0: s0 <= op(all-0, data); next state IDLE.
  - HOLD, select=1: s0 <= op(all-1, data); next state ACTIVE. Reselect takes priority over expiry.
  - HOLD, select=0, cnt>0: s0 held; cnt <= cnt-1.
  - HOLD, select=0, cnt=0: s0 <= op(all-0, data); next state IDLE.
- Result: after select falls, s0 stays frozen for exactly hold_cycles edges.
- holding[p] = (state==HOLD). It is combinational from the state register, with no pipeline delay.
- Stages 1..num_stages-1 form a plain shift register with no enable. data_out is the last stage.
- Latency from data/select sample to data_out is num_stages edges.
- Ports are fully independent; no cross-port interaction.
- Reset asserted mid-HOLD aborts the hold immediately: IDLE, outputs 0.
- Synthesis/elaboration error if num_stages is outside 1..4 or hold_cycles is outside 0..255.

Optional Feature:
- Macro: C_GATE_BITS_HOLD_STATS_EN.
- Defined:
  - Adds output hold_expired_cnt [0:num_ports*8-1], one 8-bit counter per port.
  - Each counter saturates at 255 and increments on every HOLD->IDLE expiry. Reselect exits from HOLD are not counted.
  - Counters are cleared by reset.
- Undefined: the port and counters are absent. All other behaviour is identical.

Decomposition:
- Op constants stay in c_constants.sv.
- New package c_gate_pkg holds:
  - the hold-state enum (IDLE=2'b00, ACTIVE=2'b01, HOLD=2'b10);
  - max stage count constant 4;
  - max hold constant 255.
- Sub-module c_gate_hold_ctrl: one port's FSM plus hold counter (and, under the macro, its stats counter). Outputs are s0 load-enable, gate bit and holding.
- Top level generates one c_gate_hold_ctrl per port.
- The op itself is computed with the existing c_binary_op (num_ports=2) on {gate bit replicated, data}.

Test Plan:
- Reset: config num_ports=2, width=8, AND, hold_cycles=3, num_stages=2. Assert reset mid-stream -> data_out=16'h0000 and holding=2'b00 immediately; outputs stay 0 after release while select=0.
- Active pass: select[0]=1, port 0 data 8'hA5 sampled at edge k -> data_out[0:7]=8'hA5 after edge k+1 (2-stage latency). Port 1 with select=0 stays 8'h00.
- Hold/expiry: port 0 ACTIVE with 8'hA5; at edge k select=0 and data=8'h3C -> holding=1 for edges k..k+2 and data_out stays 8'hA5; s0=8'h00 at edge k+3, data_out=8'h00 after edge k+4, holding=0.
- Reselect in HOLD: select falls at edge k, select=1 with data 8'h5A at edge k+1 -> state ACTIVE, holding=0 after edge k+1, data_out=8'h5A after edge k+2; no expiry counted (stats counter unchanged when macro defined).
- hold_cycles=0 with op=`BINARY_OP_OR, num_stages=1: select=1 data 8'h0F -> data_out 8'hFF next edge; select=0 -> data_out 8'h0F next edge; holding never asserts.
- Stats (macro defined): 300 select pulses, each followed by full hold expiry -> hold_expired_cnt for that port saturates at 8'd255; other port's counter stays 0.
